// File: rtl/ddr3_device_responder_if.sv
// DDR3 pin bundle between a memory controller and the device responder.
// Command/address/write-data travel controller -> device; read data and its
// output-enable travel device -> controller.
//   ck_en, cs_n, ras_n, cas_n, we_n : CKE, chip select and command bits
//   address, bank_address           : row/column/mode value and bank/MR select
//   dq_in                           : write data from the controller
//   dq_out, dq_oe                   : read data and its one-cycle valid beat
interface ddr3_device_responder_if #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16
);
  logic                             ck_en;
  logic                             cs_n;
  logic                             ras_n;
  logic                             cas_n;
  logic                             we_n;
  logic [ADDRESS_BITWIDTH-1:0]      address;
  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address;
  logic [DQ_BITWIDTH-1:0]           dq_in;
  logic [DQ_BITWIDTH-1:0]           dq_out;
  logic                             dq_oe;

  modport master (
    output ck_en, cs_n, ras_n, cas_n, we_n, address, bank_address, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  ck_en, cs_n, ras_n, cas_n, we_n, address, bank_address, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/ddr3_device_responder.sv
// SDR-simplified DDR3 device model for controller loopback. Decodes commands,
// tracks open banks/rows, stores write data in a small array indexed by
// {bank, low column bits}, returns read data after the CAS latency and flags
// the first protocol violation.
//   clk, reset        : clock, synchronous active-high reset
//   reset_n           : DDR reset pin, active-low, synchronous clear
//   ddr (slave)       : command/address/data pins
//   protocol_error    : sticky error flag
//   error_code        : code of the first error
//   refresh_count     : accepted REFRESH commands (wrapping)
//   open_bank_mask    : one bit per open bank
module ddr3_device_responder #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int COL_INDEX_BITS        = 3,
  parameter int DEFAULT_CL            = 5,
  parameter int DEFAULT_CWL           = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                reset_n,
  ddr3_device_responder_if.slave              ddr,
  output logic                                protocol_error,
  output logic [2:0]                          error_code,
  output logic [15:0]                         refresh_count,
  output logic [2**BANK_ADDRESS_BITWIDTH-1:0] open_bank_mask
);
  localparam int NUM_BANKS  = 2**BANK_ADDRESS_BITWIDTH;
  localparam int IDX_BITS   = BANK_ADDRESS_BITWIDTH + COL_INDEX_BITS;
  localparam int MEM_DEPTH  = 2**IDX_BITS;
  localparam int PIPE_DEPTH = 16;

  typedef enum logic [2:0] {
    CMD_MRS       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVATE  = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_ZQCL      = 3'b110,
    CMD_NOP       = 3'b111
  } cmd_e;

  logic                        clear;
  cmd_e                        cmd;
  logic [IDX_BITS-1:0]         cmd_idx;
  logic                        bank_open;
  logic                        any_open;
  logic [3:0]                  cl_q;
  logic [3:0]                  cwl_q;
  logic [3:0]                  mr0_cl;
  logic [3:0]                  mr2_cwl;

  logic                        do_act;
  logic                        do_rd;
  logic                        do_wr;
  logic                        do_pre;
  logic                        do_pre_all;
  logic                        do_ref;
  logic                        load_cl;
  logic                        load_cwl;
  logic                        err_hit;
  logic [2:0]                  err_code_now;

  // Latency pipelines: an entry is inserted at slot latency-1 and shifts one
  // slot toward 0 per cycle, so it acts exactly `latency` edges after issue and
  // keeps the latency in force when it was issued.
  logic [PIPE_DEPTH-1:0]       rd_valid;
  logic [PIPE_DEPTH-1:0]       wr_valid;
  logic [IDX_BITS-1:0]         rd_idx [PIPE_DEPTH];
  logic [IDX_BITS-1:0]         wr_idx [PIPE_DEPTH];

  logic [DQ_BITWIDTH-1:0]      mem [MEM_DEPTH];
  logic [ADDRESS_BITWIDTH-1:0] open_row [NUM_BANKS];

  assign clear     = reset | ~reset_n;
  assign cmd       = cmd_e'({ddr.ras_n, ddr.cas_n, ddr.we_n});
  assign cmd_idx   = {ddr.bank_address, ddr.address[COL_INDEX_BITS-1:0]};
  assign bank_open = open_bank_mask[ddr.bank_address];
  assign any_open  = |open_bank_mask;
  assign mr0_cl    = {1'b0, ddr.address[6:4]} + 4'd4;
  assign mr2_cwl   = {1'b0, ddr.address[5:3]} + 4'd5;

  always_comb begin
    do_act       = 1'b0;
    do_rd        = 1'b0;
    do_wr        = 1'b0;
    do_pre       = 1'b0;
    do_pre_all   = 1'b0;
    do_ref       = 1'b0;
    load_cl      = 1'b0;
    load_cwl     = 1'b0;
    err_hit      = 1'b0;
    err_code_now = 3'd0;
    if (ddr.ck_en && !ddr.cs_n) begin
      unique case (cmd)
        CMD_ACTIVATE: begin
          do_act = 1'b1;
          if (bank_open) begin
            err_hit      = 1'b1;
            err_code_now = 3'd1;
          end
        end
        CMD_READ: begin
          if (bank_open) do_rd = 1'b1;
          else begin
            err_hit      = 1'b1;
            err_code_now = 3'd2;
          end
        end
        CMD_WRITE: begin
          if (bank_open) do_wr = 1'b1;
          else begin
            err_hit      = 1'b1;
            err_code_now = 3'd3;
          end
        end
        CMD_PRECHARGE: begin
          if (ddr.address[10]) do_pre_all = 1'b1;
          else                 do_pre     = 1'b1;
        end
        CMD_REFRESH: begin
          do_ref = 1'b1;
          if (any_open) begin
            err_hit      = 1'b1;
            err_code_now = 3'd4;
          end
        end
        CMD_MRS: begin
          if (ddr.bank_address == BANK_ADDRESS_BITWIDTH'(0)) begin
            if (!ddr.address[2] && mr0_cl >= 4'd5 && mr0_cl <= 4'd11) load_cl = 1'b1;
            else begin
              err_hit      = 1'b1;
              err_code_now = 3'd5;
            end
          end else if (ddr.bank_address == BANK_ADDRESS_BITWIDTH'(2)) begin
            if (mr2_cwl <= 4'd8) load_cwl = 1'b1;
            else begin
              err_hit      = 1'b1;
              err_code_now = 3'd5;
            end
          end
          // An open bank is the more fundamental violation, so it wins the code.
          if (any_open) begin
            err_hit      = 1'b1;
            err_code_now = 3'd4;
          end
        end
        default: ;
      endcase
    end else if (!ddr.ck_en && !ddr.cs_n && cmd != CMD_NOP) begin
      err_hit      = 1'b1;
      err_code_now = 3'd6;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      ddr.dq_out     <= '0;
      ddr.dq_oe      <= 1'b0;
      protocol_error <= 1'b0;
      error_code     <= 3'd0;
      refresh_count  <= 16'd0;
      open_bank_mask <= '0;
      cl_q           <= 4'(DEFAULT_CL);
      cwl_q          <= 4'(DEFAULT_CWL);
      rd_valid       <= '0;
      wr_valid       <= '0;
    end else begin
      rd_valid <= {1'b0, rd_valid[PIPE_DEPTH-1:1]};
      wr_valid <= {1'b0, wr_valid[PIPE_DEPTH-1:1]};
      for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
        rd_idx[i] <= rd_idx[i+1];
        wr_idx[i] <= wr_idx[i+1];
      end
      if (do_rd) begin
        rd_valid[cl_q - 4'd1] <= 1'b1;
        rd_idx[cl_q - 4'd1]   <= cmd_idx;
      end
      if (do_wr) begin
        wr_valid[cwl_q - 4'd1] <= 1'b1;
        wr_idx[cwl_q - 4'd1]   <= cmd_idx;
      end

      // Reads the array before this edge's write lands: old data on a collision.
      ddr.dq_oe <= rd_valid[0];
      if (rd_valid[0]) ddr.dq_out <= mem[rd_idx[0]];

      if (do_act) begin
        open_bank_mask[ddr.bank_address] <= 1'b1;
        open_row[ddr.bank_address]       <= ddr.address;
      end
      if (do_pre_all)  open_bank_mask <= '0;
      else if (do_pre) open_bank_mask[ddr.bank_address] <= 1'b0;

      if (do_ref)   refresh_count <= refresh_count + 16'd1;
      if (load_cl)  cl_q  <= mr0_cl;
      if (load_cwl) cwl_q <= mr2_cwl;

      if (err_hit && !protocol_error) begin
        protocol_error <= 1'b1;
        error_code     <= err_code_now;
      end
    end
  end

  // Storage survives reset; only the pending write is cancelled.
  always_ff @(posedge clk) begin
    if (!clear && wr_valid[0]) mem[wr_idx[0]] <= ddr.dq_in;
  end
endmodule

// File: tb/tb_ddr3_device_responder.sv
`timescale 1ns/1ps
module tb_ddr3_device_responder;
  localparam int AW = 15;
  localparam int BW = 3;
  localparam int DW = 16;
  localparam int CB = 3;
  localparam int NB = 8;
  localparam int NW = 64;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_ZQ  = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_n;
  logic        protocol_error;
  logic [2:0]  error_code;
  logic [15:0] refresh_count;
  logic [7:0]  open_bank_mask;

  ddr3_device_responder_if #(
    .ADDRESS_BITWIDTH(AW), .BANK_ADDRESS_BITWIDTH(BW), .DQ_BITWIDTH(DW)
  ) bus ();

  ddr3_device_responder #(
    .ADDRESS_BITWIDTH(AW), .BANK_ADDRESS_BITWIDTH(BW), .DQ_BITWIDTH(DW),
    .COL_INDEX_BITS(CB), .DEFAULT_CL(5), .DEFAULT_CWL(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reset_n(reset_n),
    .ddr(bus),
    .protocol_error(protocol_error),
    .error_code(error_code),
    .refresh_count(refresh_count),
    .open_bank_mask(open_bank_mask)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: pending accesses are kept as (due cycle, index) records.
  typedef struct {
    int due;
    int idx;
  } pend_t;

  pend_t       rd_q[$];
  pend_t       wr_q[$];
  logic [15:0] m_mem [NW];
  int          ncyc;
  int          m_cl;
  int          m_cwl;
  bit          m_open [NB];
  bit          m_err;
  int          m_code;
  logic [15:0] m_ref;
  logic [15:0] m_dq_out;
  bit          m_dq_oe;

  function automatic void flag(input int code);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = code;
    end
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_open[i];
    return v;
  endfunction

  task automatic model_edge();
    logic [2:0]  c;
    logic [14:0] a;
    int          ba;
    int          idx;
    int          v;
    bit          any;
    ncyc++;
    if (reset || !reset_n) begin
      rd_q.delete();
      wr_q.delete();
      m_cl = 5;
      m_cwl = 5;
      for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
      m_err = 1'b0;
      m_code = 0;
      m_ref = 16'd0;
      m_dq_out = 16'd0;
      m_dq_oe = 1'b0;
      return;
    end
    m_dq_oe = 1'b0;
    for (int i = rd_q.size() - 1; i >= 0; i--) begin
      if (rd_q[i].due == ncyc) begin
        m_dq_oe  = 1'b1;
        m_dq_out = m_mem[rd_q[i].idx];
        rd_q.delete(i);
      end
    end
    for (int i = wr_q.size() - 1; i >= 0; i--) begin
      if (wr_q[i].due == ncyc) begin
        m_mem[wr_q[i].idx] = bus.dq_in;
        wr_q.delete(i);
      end
    end
    c   = {bus.ras_n, bus.cas_n, bus.we_n};
    a   = bus.address;
    ba  = int'(bus.bank_address);
    idx = ba * 8 + int'(a[2:0]);
    any = 1'b0;
    for (int i = 0; i < NB; i++) any |= m_open[i];
    if (bus.ck_en && !bus.cs_n) begin
      case (c)
        C_ACT: begin
          if (m_open[ba]) flag(1);
          m_open[ba] = 1'b1;
        end
        C_RD: begin
          if (!m_open[ba]) flag(2);
          else rd_q.push_back('{ncyc + m_cl, idx});
        end
        C_WR: begin
          if (!m_open[ba]) flag(3);
          else wr_q.push_back('{ncyc + m_cwl, idx});
        end
        C_PRE: begin
          if (a[10]) for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
          else m_open[ba] = 1'b0;
        end
        C_REF: begin
          if (any) flag(4);
          m_ref = m_ref + 16'd1;
        end
        C_MRS: begin
          if (any) flag(4);
          if (ba == 0) begin
            v = int'(a[6:4]) + 4;
            if (!a[2] && v >= 5 && v <= 11) m_cl = v;
            else flag(5);
          end else if (ba == 2) begin
            v = int'(a[5:3]) + 5;
            if (v <= 8) m_cwl = v;
            else flag(5);
          end
        end
        default: ;
      endcase
    end else if (!bus.ck_en && !bus.cs_n && c != C_NOP) begin
      flag(6);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input int ba, input int a);
    bus.ck_en        = 1'b1;
    bus.cs_n         = 1'b0;
    bus.ras_n        = c[2];
    bus.cas_n        = c[1];
    bus.we_n         = c[0];
    bus.bank_address = 3'(ba);
    bus.address      = 15'(a);
  endtask

  task automatic do_reset();
    drive(C_NOP, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(C_NOP, 0, 0);
    reset = 1'b1;
    step();
    step();
    n_checks++; if (bus.dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out got=%h exp=0000", bus.dq_out); end
    n_checks++; if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe got=%b exp=0", bus.dq_oe); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", protocol_error); end
    n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", error_code); end
    n_checks++; if (refresh_count !== 16'd0) begin n_fail++; $display("FAIL reset_refcnt got=%0d exp=0", refresh_count); end
    n_checks++; if (open_bank_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask got=%h exp=00", open_bank_mask); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int b = 0; b < NB; b++) begin
      drive(C_ACT, b, 0);
      step();
    end
    for (int w = 0; w < NW; w++) begin
      drive(C_WR, w / 8, w % 8);
      bus.dq_in = 16'($urandom);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      drive(C_NOP, 0, 0);
      bus.dq_in = 16'($urandom);
      step();
    end
    drive(C_PRE, 0, 16'h0400);
    step();
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL fill_perr got=%b exp=0", protocol_error); end
    n_checks++; if (open_bank_mask !== 8'h00) begin n_fail++; $display("FAIL fill_mask got=%h exp=00", open_bank_mask); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(C_ACT, 0, 5);
    step();
    drive(C_WR, 0, 2);
    bus.dq_in = 16'h0000;
    step();
    for (int k = 1; k <= 5; k++) begin
      drive(C_NOP, 0, 0);
      bus.dq_in = (k == 5) ? 16'h1234 : 16'h0000;
      step();
    end
    bus.dq_in = 16'h0000;
    drive(C_RD, 0, 2);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(C_NOP, 0, 0);
      step();
      n_checks++;
      if (bus.dq_oe !== (k == 5)) begin n_fail++; $display("FAIL basic_oe k=%0d got=%b exp=%b", k, bus.dq_oe, (k == 5)); end
      if (k == 5) begin
        n_checks++;
        if (bus.dq_out !== 16'h1234) begin n_fail++; $display("FAIL basic_data got=%h exp=1234", bus.dq_out); end
      end
    end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL basic_perr got=%b exp=0", protocol_error); end
  endtask

  task automatic test_mrs_latency();
    do_reset();
    drive(C_MRS, 0, 16'h0030);
    step();
    drive(C_MRS, 2, 16'h0018);
    step();
    drive(C_ACT, 1, 0);
    step();
    drive(C_WR, 1, 4);
    bus.dq_in = 16'h0000;
    step();
    for (int k = 1; k <= 9; k++) begin
      drive(C_NOP, 0, 0);
      bus.dq_in = (k == 8) ? 16'hBEEF : 16'h0000;
      step();
    end
    drive(C_RD, 1, 4);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(C_NOP, 0, 0);
      step();
      n_checks++;
      if (bus.dq_oe !== (k == 7)) begin n_fail++; $display("FAIL mrs_oe k=%0d got=%b exp=%b", k, bus.dq_oe, (k == 7)); end
      if (k == 7) begin
        n_checks++;
        if (bus.dq_out !== 16'hBEEF) begin n_fail++; $display("FAIL mrs_data got=%h exp=beef", bus.dq_out); end
      end
    end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL mrs_perr got=%b exp=0", protocol_error); end
    drive(C_PRE, 0, 16'h0400);
    step();
    drive(C_MRS, 0, 16'h0000);
    step();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL mrs_bad_perr got=%b exp=1", protocol_error); end
    n_checks++; if (error_code !== 3'd5) begin n_fail++; $display("FAIL mrs_bad_code got=%0d exp=5", error_code); end
    drive(C_ACT, 1, 0);
    step();
    drive(C_RD, 1, 4);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(C_NOP, 0, 0);
      step();
      n_checks++;
      if (bus.dq_oe !== (k == 7)) begin n_fail++; $display("FAIL mrs_keep_oe k=%0d got=%b exp=%b", k, bus.dq_oe, (k == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(C_ACT, 2, 0);
    step();
    for (int i = 0; i <= 9; i++) begin
      drive((i < 4) ? C_WR : C_NOP, 2, i);
      bus.dq_in = (i >= 5 && i <= 8) ? 16'(i - 5) : 16'hFFFF;
      step();
    end
    for (int k = 0; k <= 10; k++) begin
      drive((k < 4) ? C_RD : C_NOP, 2, k);
      step();
      n_checks++;
      if (bus.dq_oe !== (k >= 5 && k <= 8)) begin n_fail++; $display("FAIL b2b_oe k=%0d got=%b exp=%b", k, bus.dq_oe, (k >= 5 && k <= 8)); end
      if (k >= 5 && k <= 8) begin
        n_checks++;
        if (bus.dq_out !== 16'(k - 5)) begin n_fail++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.dq_out, 16'(k - 5)); end
      end
    end
  endtask

  task automatic test_closed_bank();
    do_reset();
    drive(C_RD, 3, 0);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(C_NOP, 0, 0);
      step();
      n_checks++;
      if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL closed_oe k=%0d got=%b exp=0", k, bus.dq_oe); end
    end
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL closed_perr got=%b exp=1", protocol_error); end
    n_checks++; if (error_code !== 3'd2) begin n_fail++; $display("FAIL closed_code got=%0d exp=2", error_code); end
    drive(C_ACT, 0, 1);
    step();
    drive(C_ACT, 0, 2);
    step();
    n_checks++; if (error_code !== 3'd2) begin n_fail++; $display("FAIL closed_sticky got=%0d exp=2", error_code); end
    n_checks++; if (open_bank_mask !== 8'h01) begin n_fail++; $display("FAIL closed_mask got=%h exp=01", open_bank_mask); end
  endtask

  task automatic test_precharge_refresh();
    do_reset();
    drive(C_ACT, 0, 3);
    step();
    drive(C_ACT, 7, 4);
    step();
    n_checks++; if (open_bank_mask !== 8'h81) begin n_fail++; $display("FAIL pre_mask_open got=%h exp=81", open_bank_mask); end
    drive(C_PRE, 0, 16'h0400);
    step();
    n_checks++; if (open_bank_mask !== 8'h00) begin n_fail++; $display("FAIL pre_all got=%h exp=00", open_bank_mask); end
    for (int k = 0; k < 3; k++) begin
      drive(C_REF, 0, 0);
      step();
    end
    n_checks++; if (refresh_count !== 16'd3) begin n_fail++; $display("FAIL ref_count got=%0d exp=3", refresh_count); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL ref_perr got=%b exp=0", protocol_error); end
    drive(C_ACT, 2, 0);
    step();
    drive(C_ACT, 5, 0);
    step();
    drive(C_PRE, 2, 0);
    step();
    n_checks++; if (open_bank_mask !== 8'h20) begin n_fail++; $display("FAIL pre_single got=%h exp=20", open_bank_mask); end
    drive(C_PRE, 5, 0);
    step();
    drive(C_ACT, 1, 0);
    step();
    drive(C_REF, 0, 0);
    step();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL ref_open_perr got=%b exp=1", protocol_error); end
    n_checks++; if (error_code !== 3'd4) begin n_fail++; $display("FAIL ref_open_code got=%0d exp=4", error_code); end
    n_checks++; if (refresh_count !== 16'd4) begin n_fail++; $display("FAIL ref_open_count got=%0d exp=4", refresh_count); end
  endtask

  task automatic test_reset_midflight(input bit use_pin);
    do_reset();
    drive(C_REF, 0, 0);
    step();
    drive(C_RD, 6, 0);
    step();
    drive(C_ACT, 0, 0);
    step();
    drive(C_RD, 0, 2);
    step();
    drive(C_NOP, 0, 0);
    step();
    if (use_pin) reset_n = 1'b0;
    else         reset   = 1'b1;
    step();
    reset_n = 1'b1;
    reset   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (bus.dq_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe pin=%0d k=%0d got=%b exp=0", use_pin, k, bus.dq_oe); end
    end
    n_checks++; if (bus.dq_out !== 16'h0) begin n_fail++; $display("FAIL midrst_dq pin=%0d got=%h exp=0000", use_pin, bus.dq_out); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL midrst_perr pin=%0d got=%b exp=0", use_pin, protocol_error); end
    n_checks++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL midrst_code pin=%0d got=%0d exp=0", use_pin, error_code); end
    n_checks++; if (refresh_count !== 16'd0) begin n_fail++; $display("FAIL midrst_ref pin=%0d got=%0d exp=0", use_pin, refresh_count); end
    n_checks++; if (open_bank_mask !== 8'h00) begin n_fail++; $display("FAIL midrst_mask pin=%0d got=%h exp=00", use_pin, open_bank_mask); end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] c;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 15));
      if (r <= 2)       c = C_ACT;
      else if (r <= 6)  c = C_RD;
      else if (r <= 10) c = C_WR;
      else if (r == 11) c = C_PRE;
      else if (r == 12) c = C_REF;
      else if (r == 13) c = (rd_q.size() == 0 && wr_q.size() == 0) ? C_MRS : C_NOP;
      else if (r == 14) c = C_NOP;
      else              c = C_ZQ;
      drive(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 32767)));
      if (c == C_MRS) bus.bank_address = 3'($urandom_range(0, 2));
      bus.ck_en = ($urandom_range(0, 31) != 0);
      bus.cs_n  = ($urandom_range(0, 7) == 0);
      bus.dq_in = 16'($urandom);
      reset     = (n % 150 == 149);
      step();
      n_checks++; if (bus.dq_oe !== m_dq_oe) begin n_fail++; $display("FAIL rnd_oe n=%0d got=%b exp=%b", n, bus.dq_oe, m_dq_oe); end
      n_checks++; if (bus.dq_out !== m_dq_out) begin n_fail++; $display("FAIL rnd_dq n=%0d got=%h exp=%h", n, bus.dq_out, m_dq_out); end
      n_checks++; if (protocol_error !== m_err) begin n_fail++; $display("FAIL rnd_perr n=%0d got=%b exp=%b", n, protocol_error, m_err); end
      n_checks++; if (error_code !== 3'(m_code)) begin n_fail++; $display("FAIL rnd_code n=%0d got=%0d exp=%0d", n, error_code, m_code); end
      n_checks++; if (refresh_count !== m_ref) begin n_fail++; $display("FAIL rnd_ref n=%0d got=%0d exp=%0d", n, refresh_count, m_ref); end
      n_checks++; if (open_bank_mask !== m_mask()) begin n_fail++; $display("FAIL rnd_mask n=%0d got=%h exp=%h", n, open_bank_mask, m_mask()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ncyc      = 0;
    reset     = 1'b1;
    reset_n   = 1'b1;
    bus.dq_in = 16'h0;
    drive(C_NOP, 0, 0);
    test_reset();
    test_fill();
    test_basic();
    test_mrs_latency();
    test_back_to_back();
    test_closed_bank();
    test_precharge_refresh();
    test_reset_midflight(1'b0);
    test_reset_midflight(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
